// File: rtl/gray_ptr_sync_w.sv
// Write-side Gray read-pointer synchronizer: N-flop sync, Gray->binary, update pulse, free/full flags.
// Optional macro GRAY_CHECK_EN builds the sticky multi-bit-change detector (gray_err); otherwise gray_err is 0.
module gray_ptr_sync_w #(
    parameter int ADDR_W   = 8,
    parameter int STAGES   = 2,
    parameter int AFULL_TH = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [ADDR_W:0]   rptr,
    input  logic [ADDR_W:0]   wptr_bin,
    input  logic              err_clr,
    output logic [ADDR_W:0]   wq_rptr_gray,
    output logic [ADDR_W:0]   wq_rptr_bin,
    output logic              rptr_upd,
    output logic              gray_err,
    output logic [ADDR_W:0]   wfree,
    output logic              wfull,
    output logic              walmost_full
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_V = (ADDR_W+1)'(AFULL_TH);

    if (STAGES < 2) begin : g_stages_bad
        $error("gray_ptr_sync_w: STAGES must be at least 2");
    end

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] sync_q [STAGES];
    logic [ADDR_W:0] gprev_q;
    logic [ADDR_W:0] bin_q, bin_d;
    logic            upd_q, upd_d;

    // Pure flop chain: no logic between stages so each stage can resolve metastability.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr_gray = sync_q[STAGES-1];

    always_comb begin
        bin_d = gray2bin(wq_rptr_gray);
        upd_d = (wq_rptr_gray != gprev_q);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            gprev_q <= '0;
            bin_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            gprev_q <= wq_rptr_gray;
            bin_q   <= bin_d;
            upd_q   <= upd_d;
        end
    end

    assign wq_rptr_bin = bin_q;
    assign rptr_upd    = upd_q;

`ifdef GRAY_CHECK_EN
    logic [ADDR_W:0] gdiff;
    logic            multi_bit;
    logic            err_q, err_d;

    // A value with more than one bit set has a nonzero result after clearing its lowest set bit.
    always_comb begin
        gdiff     = wq_rptr_gray ^ gprev_q;
        multi_bit = ((gdiff & (gdiff - (ADDR_W+1)'(1))) != '0);
        err_d     = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (multi_bit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign gray_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign gray_err       = 1'b0;
`endif

    // Modulo subtraction absorbs the lap bit; an MSB-set result means full or overrun.
    logic [ADDR_W:0] occ;

    always_comb begin
        occ          = wptr_bin - bin_q;
        wfull        = occ[ADDR_W];
        wfree        = occ[ADDR_W] ? '0 : (DEPTH - occ);
        walmost_full = (wfree <= AFULL_V);
    end

endmodule

// File: doc/gray_ptr_sync_w.md
Name: gray_ptr_sync_w

Overview:
- Parametrised successor to the fixed 2-flop read-pointer synchronizer.
- Brings the Gray-coded read pointer of the UART async FIFO into the write-clock domain through a configurable number of flop stages.
- Converts the synchronized pointer to binary, flags pointer updates, and checks Gray-code integrity.
- Computes free space, full and almost-full for the FIFO write side, given the local binary write pointer.

Parameters:
- ADDR_W, 8: FIFO address width. Pointers are ADDR_W+1 bits. Depth = 2^ADDR_W.
- STAGES, 2: number of synchronizer flops, minimum 2. Values below 2 are a elaboration error (generate block issues $error).
- AFULL_TH, 4: almost-full asserts when free entries <= AFULL_TH. Range 0..2^ADDR_W.

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- rptr  in  ADDR_W+1  Gray-coded read pointer from the read domain (asynchronous to wclk)
- wptr_bin  in  ADDR_W+1  local binary write pointer (wclk domain)
- err_clr  in  1  clears gray_err, level-sampled on wclk
- wq_rptr_gray  out  ADDR_W+1  synchronized Gray read pointer
- wq_rptr_bin  out  ADDR_W+1  registered binary of wq_rptr_gray
- rptr_upd  out  1  one-cycle pulse when wq_rptr_bin takes a new value
- gray_err  out  1  sticky flag: more than one bit changed between consecutive synchronized samples
- wfree  out  ADDR_W+1  free entries, 0..2^ADDR_W
- wfull  out  1  FIFO full
- walmost_full  out  1  free entries <= AFULL_TH

Behaviour:
- Reset: wrst_n low asynchronously clears every flop.
  - wq_rptr_gray, wq_rptr_bin, rptr_upd and gray_err are 0.
  - With wptr_bin=0: wfree=2^ADDR_W and wfull=0.
  - Mid-operation reset discards all pipeline contents immediately, with no partial update.
- Sync chain: STAGES flops in series, no logic between them. wq_rptr_gray is the last stage, so latency from rptr to wq_rptr_gray is STAGES edges.
- A delay register gprev holds wq_rptr_gray from the previous cycle.
- Binary stage: wq_rptr_bin <= gray2bin(wq_rptr_gray), registered, so latency is STAGES+1 edges. gray2bin is the XOR prefix from the MSB down.
- rptr_upd <= (wq_rptr_gray != gprev). It asserts in the same cycle wq_rptr_bin shows the new value, and stays high for consecutive cycles if the pointer moves every cycle.
- gray_err:
  - Set on the edge where popcount(wq_rptr_gray ^ gprev) > 1.
  - Cleared on an edge with err_clr=1.
  - If set and clear occur on the same edge, set wins.
- Occupancy, combinational: occ = (wptr_bin - wq_rptr_bin) mod 2^(ADDR_W+1).
  - Wrap-around of the MSB (lap bit) is handled by the modulo.
  - occ >= 2^ADDR_W (full or illegal overrun): wfree=0, wfull=1.
  - Otherwise: wfree = 2^ADDR_W - occ, wfull=0.
  - walmost_full = (wfree <= AFULL_TH).
  - These flags are pessimistic by design, because the read pointer lags by STAGES+1 cycles.
- Simultaneous write and read movement: no arbitration. Flags reflect the current wptr_bin against the latest registered wq_rptr_bin.

Optional Feature:
- Macro: GRAY_CHECK_EN.
- Defined: gprev popcount checker and sticky gray_err are built as described.
- Undefined: popcount logic is removed, gray_err is tied to 0, and err_clr is ignored. gprev remains, because rptr_upd still needs it.

Test Plan (ADDR_W=3, STAGES=2, AFULL_TH=2):
- Reset then idle: all outputs 0 except wfree=8. Drive rptr=4'b0111 (bin 5) at edge 0: wq_rptr_gray=0111 after edge 2; wq_rptr_bin=5 and rptr_upd=1 for exactly one cycle after edge 3.
- wptr_bin=8, rptr Gray of 0: wfree=0, wfull=1, walmost_full=1. Step rptr to Gray 1: wfree=1, wfull=0 appear 3 edges later.
- Wrap: wptr_bin=4'b0010, rptr Gray of binary 12 (4'b1010): occ=6, wfree=2, walmost_full=1, wfull=0.
- Gray fault (GRAY_CHECK_EN defined): rptr jumps 0000 to 0011. gray_err=1 after edge 3 and holds. err_clr pulse clears it. err_clr asserted on the same edge as a new fault leaves gray_err=1.
- Without GRAY_CHECK_EN, same fault stimulus: gray_err stays 0, and rptr_upd still pulses.
- Assert wrst_n low mid-stream with rptr changing: all flops are 0 immediately. After release, the first synchronized value appears STAGES edges later with no spurious rptr_upd.
